shift_stage: RTL
================

Name: shift_stage

Overview:
- Execute-stage wrapper for RV32I shift instructions: SLL, SRL, SRA, SLLI, SRLI and SRAI.
- Decodes funct3/funct7 into shift controls, selects shamt, computes the result through the combinational barrel shifter, and registers it toward writeback.
- Valid/ready on both sides; a 2-entry skid buffer gives full throughput under backpressure.
- Sits between the issue/decode register and the writeback arbiter.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- TAGW, 5, width of the destination register tag.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  synchronous active-low reset, sampled on rising edge of clk
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept this cycle
- funct3  in  3  instruction bits [14:12]
- funct7  in  7  instruction bits [31:25]
- is_imm  in  1  1 = immediate form (shamt from imm), 0 = register form
- rs1_data  in  XLEN  operand to shift
- rs2_data  in  XLEN  shamt source for register form; only bits [4:0] are used
- imm_shamt  in  5  instruction bits [24:20]
- rd  in  TAGW  destination tag
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts
- out_data  out  XLEN  shifted result
- out_rd  out  TAGW  tag of out_data

Behaviour:
- Reset (rstn=0 at an edge): out_valid=0, skid valid=0, out_data=0, out_rd=0, in_ready=1 from the next cycle. Reset overrides flush and all handshakes; an instruction in flight is discarded.
- Accept: a transfer occurs when in_valid && in_ready at the edge. Transfer out when out_valid && out_ready.
- Decode:
  - right = funct3[2] (001 selects left, 101 selects right).
  - arith = right && funct7[5].
  - shamt = is_imm ? imm_shamt : rs2_data[4:0].
- Shift is computed combinationally in the accept cycle; only the result and rd are stored, never the operands.
- Latency: accepted at edge N, so out_valid=1 in cycle N+1 if the output register is empty or drains at edge N.
- Storage: output register (OUT) plus skid register (SKID). Occupancy is 0..2.
- in_ready = !skid_valid, registered, with no combinational path from out_ready.
- Edge rules, in priority order:
  - flush: OUT and SKID are invalidated and the input is ignored in the same cycle. in_ready=1 next cycle.
  - OUT drains, SKID valid: SKID moves to OUT. A new accept is impossible because in_ready=0.
  - OUT drains or is empty, SKID empty: a new accept loads OUT.
  - OUT held, SKID empty: a new accept loads SKID.
- Order is strictly FIFO; results are never reordered or duplicated.
- out_data and out_rd are stable while out_valid && !out_ready.
- Boundaries:
  - shamt=0 passes rs1_data unchanged.
  - shamt=31 is the maximum; no shamt wrap beyond 5 bits.
  - Simultaneous drain and accept at occupancy 1 keeps occupancy at 1.

Optional Feature:
- Macro: SHIFT_STAGE_ILLEGAL_CHECK_EN.
- With the macro defined:
  - Adds output port out_illegal (1 bit, reset 0), registered with each entry.
  - An entry is illegal if funct3 is not 001 or 101, or funct7 is not 0000000 or 0100000, or funct3=001 with funct7=0100000.
  - An illegal entry gives out_data=0 and out_illegal=1; the handshake is unchanged.
- Without the macro: the port is absent, funct7 bits other than [5] are ignored, and funct3[1:0] is ignored.

Decomposition:
- Package shift_stage_pkg holds:
  - constants F3_SLL=3'b001, F3_SR=3'b101, F7_BASE=7'b0000000, F7_ALT=7'b0100000.
  - packed struct entry_t {data, rd, illegal}, with illegal present only under the macro.
- Sub-module: instantiate the existing combinational barrel shifter, module shift (d, shamt, right, arith, shifted).
- The OUT/SKID logic stays inline.

Test Plan:
- SLL: rs1=0x0000_0001, rs2=0x0000_0004, is_imm=0, rd=3 -> one cycle later out_valid=1, out_data=0x0000_0010, out_rd=3.
- SRAI and SRLI: rs1=0x8000_0000, imm_shamt=31.
  - funct7=0100000 -> out_data=0xFFFF_FFFF.
  - funct7=0000000 -> out_data=0x0000_0001.
- Backpressure: out_ready=0, issue A (rd=1) then B (rd=2).
  - After B, in_ready=0 and out holds A.
  - Raise out_ready -> A then B on consecutive cycles, then in_ready=1.
  - Attempt C while in_ready=0 -> C is not accepted.
- Flush with occupancy 2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, no result emitted.
- Reset mid-stream: rstn=0 for one edge while OUT holds 0x1234 -> out_valid=0, out_data=0; after release, in_ready=1.
- Macro defined: funct3=001, funct7=0100000 -> out_illegal=1, out_data=0. SRL with shamt=0 and rs1=0xDEAD_BEEF -> out_illegal=0, out_data=0xDEAD_BEEF.

Source files
------------

// File: rtl/shift_stage_pkg.sv
// Shared constants and the stored-entry type for the RV32I shift execute stage.
// Optional macro SHIFT_STAGE_ILLEGAL_CHECK_EN adds the illegal flag to each entry.
package shift_stage_pkg;

    localparam int XLEN_P = 32;
    localparam int TAGW_P = 5;

    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN_P-1:0] data;
        logic [TAGW_P-1:0] rd;
`ifdef SHIFT_STAGE_ILLEGAL_CHECK_EN
        logic              illegal;
`endif
    } entry_t;

`ifdef SHIFT_STAGE_ILLEGAL_CHECK_EN
    // SLL only exists with funct7=0; SRL/SRA take either funct7 encoding.
    function automatic logic is_illegal(input logic [2:0] f3, input logic [6:0] f7);
        logic legal;
        legal = ((f3 == F3_SLL) && (f7 == F7_BASE)) ||
                ((f3 == F3_SR) && ((f7 == F7_BASE) || (f7 == F7_ALT)));
        return !legal;
    endfunction
`endif

endpackage

// File: rtl/shift_stage_shift.sv
// Combinational barrel shifter: logical left, logical right or arithmetic right by shamt.
module shift #(
    parameter int W = 32
) (
    input  logic [W-1:0] d,
    input  logic [4:0]   shamt,
    input  logic         right,
    input  logic         arith,
    output logic [W-1:0] shifted
);

    // Select shift direction and fill
    always_comb begin
        shifted = d;
        if (right) begin
            if (arith) begin
                shifted = $signed(d) >>> shamt;
            end else begin
                shifted = d >> shamt;
            end
        end else begin
            shifted = d << shamt;
        end
    end

endmodule

// File: rtl/shift_stage.sv
// RV32I shift execute stage: decode, barrel shift, OUT/SKID registers toward writeback.
// Optional macro SHIFT_STAGE_ILLEGAL_CHECK_EN adds the out_illegal port.
module shift_stage
    import shift_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            is_imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      imm_shamt,
    input  logic [TAGW-1:0] rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
`ifdef SHIFT_STAGE_ILLEGAL_CHECK_EN
    output logic            out_illegal,
`endif
    output logic [TAGW-1:0] out_rd
);

    logic [4:0]      shamt_s;
    logic            right_s;
    logic            arith_s;
    logic [XLEN-1:0] shifted_s;
    logic            unused_s;

    entry_t new_s;
    entry_t out_r;
    entry_t skid_r;
    entry_t out_nxt_s;
    entry_t skid_nxt_s;

    logic out_valid_r;
    logic skid_valid_r;
    logic in_ready_r;
    logic out_valid_nxt_s;
    logic skid_valid_nxt_s;
    logic drain_s;
    logic accept_s;

`ifdef SHIFT_STAGE_ILLEGAL_CHECK_EN
    assign unused_s = ^{rs2_data[XLEN-1:5]};
`else
    assign unused_s = ^{rs2_data[XLEN-1:5], funct3[1:0], funct7[6], funct7[4:0]};
`endif

    // Decode shift controls and shift amount
    always_comb begin
        right_s = funct3[2];
        arith_s = funct3[2] & funct7[5];
        if (is_imm) begin
            shamt_s = imm_shamt;
        end else begin
            shamt_s = rs2_data[4:0];
        end
    end

    shift #(.W(XLEN)) u_shift (
        .d       (rs1_data),
        .shamt   (shamt_s),
        .right   (right_s),
        .arith   (arith_s),
        .shifted (shifted_s)
    );

    // Build the entry stored on accept; illegal encodings carry zero data
    always_comb begin
        new_s      = '0;
        new_s.rd   = rd;
`ifdef SHIFT_STAGE_ILLEGAL_CHECK_EN
        new_s.illegal = is_illegal(funct3, funct7);
        if (new_s.illegal) begin
            new_s.data = '0;
        end else begin
            new_s.data = shifted_s;
        end
`else
        new_s.data = shifted_s;
`endif
    end

    assign drain_s  = out_valid_r & out_ready;
    assign accept_s = in_valid & in_ready_r;

    // OUT/SKID next state: flush, then skid refill, then direct load, then skid capture
    always_comb begin
        out_nxt_s        = out_r;
        skid_nxt_s       = skid_r;
        out_valid_nxt_s  = out_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (flush) begin
            out_valid_nxt_s  = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (skid_valid_r) begin
            if (drain_s) begin
                out_nxt_s        = skid_r;
                out_valid_nxt_s  = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else begin
                out_valid_nxt_s  = 1'b1;
                skid_valid_nxt_s = 1'b1;
            end
        end else if (!out_valid_r || drain_s) begin
            if (accept_s) begin
                out_nxt_s       = new_s;
                out_valid_nxt_s = 1'b1;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_nxt_s       = new_s;
                skid_valid_nxt_s = 1'b1;
            end else begin
                skid_valid_nxt_s = 1'b0;
            end
        end
    end

    // State registers; in_ready is registered from next skid occupancy
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_r        <= '0;
            skid_r       <= '0;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            out_r        <= out_nxt_s;
            skid_r       <= skid_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            in_ready_r   <= ~skid_valid_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_r.data;
    assign out_rd    = out_r.rd;
`ifdef SHIFT_STAGE_ILLEGAL_CHECK_EN
    assign out_illegal = out_r.illegal;
`endif

endmodule
